// File: rtl/popacc_pkg.sv
// popacc_pkg: shared widths and types for the popcount frame accumulator
package popacc_pkg;
    localparam int CNT_W     = 5;
    localparam int MAX_COUNT = 16;
    localparam int SUM_W     = 32;
    typedef logic [CNT_W-1:0] count_t;
    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             above;
        logic             sat;
    } result_t;
endpackage

// File: rtl/popacc_valid_delay.sv
// popacc_valid_delay: LATENCY-deep valid shift register that realigns the sample tag with the counter output
module popacc_valid_delay #(
    parameter int LATENCY = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    output logic o_av
);
    logic [LATENCY-1:0] r_sh;
    // shift the tag one stage per cycle; the oldest stage is the aligned valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sh <= '0;
        else        r_sh <= (r_sh << 1) | LATENCY'(i_valid);
    end
    assign o_av = r_sh[LATENCY-1];
endmodule

// File: rtl/popcount_frame_accumulator.sv
// popcount_frame_accumulator: sums aligned popcounts per frame and offers totals over valid/ready; POPACC_SATURATE_EN clamps instead of wrapping
module popcount_frame_accumulator
    import popacc_pkg::*;
#(
    parameter int LATENCY   = 10,
    parameter int FRAME_LEN = 64,
    parameter int ACC_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  count_t           count,
    input  logic [ACC_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_above,
    output logic             out_sat,
    output logic             frame_lost
);
    localparam int IDX_W = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    logic             w_av;
    logic [ACC_W-1:0] w_cnt;
    logic [ACC_W-1:0] w_next;
    logic             w_sat;
    logic             w_done;
    logic             w_load;
    logic [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    result_t          r_res;
    logic             r_valid;
    logic             r_lost;

    popacc_valid_delay #(.LATENCY(LATENCY)) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .o_av    (w_av)
    );

    assign w_cnt  = ACC_W'(count);
    assign w_done = w_av && (r_idx == LAST);
    assign w_load = w_done && (!r_valid || out_ready);

`ifdef POPACC_SATURATE_EN
    logic [ACC_W:0] w_sum;
    logic           r_fsat;
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_cnt};
    assign w_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_sat  = r_fsat | w_sum[ACC_W];
    // remember whether the frame in progress has clipped; restart at each frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_fsat <= 1'b0;
        else if (w_av) r_fsat <= w_done ? 1'b0 : w_sat;
    end
`else
    assign w_next = r_acc + w_cnt;
    assign w_sat  = 1'b0;
`endif

    // accumulate aligned samples; a completing sample empties the accumulator for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_av) begin
            r_acc <= w_done ? '0 : w_next;
            r_idx <= w_done ? '0 : r_idx + IDX_W'(1);
        end
    end

    // result register: loads when free or being drained, otherwise the frame is dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= '0;
            r_valid <= 1'b0;
            r_lost  <= 1'b0;
        end else begin
            if (w_load) begin
                r_res.sum   <= SUM_W'(w_next);
                r_res.above <= w_next >= thresh;
                r_res.sat   <= w_sat;
            end
            r_valid <= w_load | (r_valid & ~out_ready);
            r_lost  <= r_lost | (w_done & ~w_load);
        end
    end

    assign out_valid  = r_valid;
    assign out_sum    = ACC_W'(r_res.sum);
    assign out_above  = r_res.above;
    assign out_sat    = r_res.sat;
    assign frame_lost = r_lost;
endmodule

// File: tb/tb_popcount_frame_accumulator.sv
// tb_popcount_frame_accumulator: directed and random checks of two accumulator configurations against a frame-level model
module tb_popcount_frame_accumulator;
    import popacc_pkg::*;
    localparam int LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    count_t      count = '0;
    logic [10:0] thresh = '0;
    logic        ov0, ab0, sat0, lost0, ov1, ab1, sat1, lost1;
    logic [10:0] sum0;
    logic [5:0]  sum1;

    int  nchk = 0, nerr = 0;
    bit  avq[$];
    int  pend[$];
    int  fs[2], fc[2], msum[2];
    bit  mv[2], ma[2], mst[2], ml[2];
    bit  hist[25];
    int  c, sa, sb, sf;

    popcount_frame_accumulator #(.LATENCY(LAT), .FRAME_LEN(4), .ACC_W(11)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .count(count), .thresh(thresh),
        .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0), .out_above(ab0),
        .out_sat(sat0), .frame_lost(lost0));

    popcount_frame_accumulator #(.LATENCY(LAT), .FRAME_LEN(8), .ACC_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .count(count), .thresh(thresh[5:0]),
        .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1), .out_above(ab1),
        .out_sat(sat1), .frame_lost(lost1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("valid0", ov0, mv[0]);  chk("sum0", sum0, msum[0]); chk("above0", ab0, ma[0]);
        chk("sat0", sat0, mst[0]);  chk("lost0", lost0, ml[0]);
        chk("valid1", ov1, mv[1]);  chk("sum1", sum1, msum[1]); chk("above1", ab1, ma[1]);
        chk("sat1", sat1, mst[1]);  chk("lost1", lost1, ml[1]);
    endtask

    task automatic model_clear();
        avq.delete();
        pend.delete();
        for (int i = 0; i < LAT; i++) avq.push_back(1'b0);
        for (int k = 0; k < 2; k++) begin
            fs[k] = 0; fc[k] = 0; msum[k] = 0;
            mv[k] = 0; ma[k] = 0; mst[k] = 0; ml[k] = 0;
        end
    endtask

    // frame-level reference: an integer running sum, wrapped or clamped only when the frame closes
    task automatic update(input int k, input bit av);
        int mx, tot, thr;
        bit st, done;
        mx   = (k == 1) ? 63 : 2047;
        thr  = (k == 1) ? int'(thresh[5:0]) : int'(thresh);
        done = 0;
        if (av) begin
            fs[k] += int'(count);
            fc[k]++;
            done = (fc[k] == ((k == 1) ? 8 : 4));
        end
        if (done) begin
`ifdef POPACC_SATURATE_EN
            st  = fs[k] > mx;
            tot = st ? mx : fs[k];
`else
            st  = 0;
            tot = fs[k] & mx;
`endif
            if (!mv[k] || out_ready) begin
                msum[k] = tot; ma[k] = tot >= thr; mst[k] = st; mv[k] = 1;
            end else ml[k] = 1;
            fs[k] = 0;
            fc[k] = 0;
        end else if (mv[k] && out_ready) mv[k] = 0;
    endtask

    // one clock: present a vector tag, feed the counter value due this cycle, then check after the edge
    task automatic step(input bit v, input int cv);
        bit av;
        in_valid = v;
        count = avq[0] ? count_t'(pend.pop_front()) : count_t'($urandom_range(0, 31));
        if (v) pend.push_back(cv);
        @(posedge clk);
        if (rst_n) begin
            av = avq.pop_front();
            avq.push_back(in_valid);
            for (int k = 0; k < 2; k++) update(k, av);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        thresh = 50; out_ready = 1;
        for (int s = 0; s < 25; s++) begin
            step(s < 8, 16);
            hist[s] = ov0;
            if (s == 13) begin chk("t1_sum", sum0, 64); chk("t1_above", ab0, 1); end
            if (s == 17) begin
`ifdef POPACC_SATURATE_EN
                chk("sat_sum", sum1, 63); chk("sat_flag", sat1, 1);
`else
                chk("wrap_sum", sum1, 0); chk("wrap_flag", sat1, 0);
`endif
            end
        end
        chk("t1_pulse_pre", hist[12], 0);
        chk("t1_pulse", hist[13], 1);
        chk("t1_pulse_post", hist[14], 0);

        thresh = 10;
        step(1, 3); step(0, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 5); step(1, 1);
        repeat (12) step(0, 0);
        chk("t2_sum", sum0, 9);
        chk("t2_above", ab0, 0);

        out_ready = 0; sa = 0;
        for (int i = 0; i < 8; i++) begin
            c = $urandom_range(0, 16);
            if (i < 4) sa += c;
            step(1, c);
        end
        repeat (12) step(0, 0);
        chk("hold_valid", ov0, 1);
        chk("hold_sum", sum0, sa);
        chk("hold_lost", lost0, 1);
        out_ready = 1;
        step(0, 0);
        chk("hold_drain", ov0, 0);

        for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 16));
        do_reset();
        chk("rst_valid", ov0, 0);
        chk("rst_sum", sum0, 0);
        chk("rst_lost", lost0, 0);
        sf = 0;
        for (int s = 0; s < 14; s++) begin
            c = $urandom_range(0, 16);
            if (s < 4) sf += c;
            step(s < 4, c);
            if (s == 12) chk("rst_early", ov0, 0);
            if (s == 13) begin chk("rst_first", ov0, 1); chk("rst_fsum", sum0, sf); end
        end

        step(0, 0);
        out_ready = 0; sa = 0;
        for (int s = 0; s < 14; s++) begin
            c = $urandom_range(0, 16);
            if (s < 4) sa += c;
            step(s < 4, c);
        end
        chk("same_a_valid", ov0, 1);
        chk("same_a_sum", sum0, sa);
        sb = 0;
        for (int s = 0; s < 14; s++) begin
            c = $urandom_range(0, 16);
            if (s < 4) sb += c;
            out_ready = (s == 13);
            step(s < 4, c);
        end
        chk("same_b_valid", ov0, 1);
        chk("same_b_sum", sum0, sb);
        chk("same_b_lost", lost0, 0);
        out_ready = 1;
        step(0, 0);
        chk("same_b_drain", ov0, 0);

        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            thresh = 11'($urandom_range(0, 80));
            step($urandom_range(0, 2) != 0, $urandom_range(0, 31));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
